mux81_rr_sched: RTL and testbench

Round-robin scheduler that shares one 8:1 bit mux between eight requesters. It arbitrates `req[7:0]`, drives the mux select `sel[2:0]` (s2,s1,s0), and streams the selected data bit out over a valid/ready handshake. Each grant holds for a bounded burst of beats. It sits between the eight source channels and a single serial consumer.

---
 rtl/mux_sched_pkg.sv | 7 +
 rtl/mux81.sv | 28 ++
 rtl/mux81_rr_pick8.sv | 25 ++
 rtl/mux81_rr_sched.sv | 83 ++++++++
 tb/tb_mux81_rr_sched.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mux_sched_pkg.sv
// Shared types and sizes for the round-robin 8:1 mux scheduler.
package mux_sched_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    localparam int NCH  = 8;
    localparam int SELW = 3;
    localparam int CNTW = 4;
endpackage

// File: rtl/mux81.sv
// Plain 8:1 single-bit multiplexer, select {s2,s1,s0}.
module mux81 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    input  logic i5,
    input  logic i6,
    input  logic i7,
    input  logic s2,
    input  logic s1,
    input  logic s0,
    output logic y
);
    always_comb begin
        case ({s2, s1, s0})
            3'd0:    y = i0;
            3'd1:    y = i1;
            3'd2:    y = i2;
            3'd3:    y = i3;
            3'd4:    y = i4;
            3'd5:    y = i5;
            3'd6:    y = i6;
            default: y = i7;
        endcase
    end
endmodule

// File: rtl/mux81_rr_pick8.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... mod 8.
module rr_pick8
    import mux_sched_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            any
);
    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic [SELW-1:0]  off;

    // Rotate so that bit 0 of rot is channel ptr, then take the lowest set bit.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NCH-1:0];
        off = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) off = SELW'(k);
        end
        idx = ptr + off;
        any = |req;
    end
endmodule

// File: rtl/mux81_rr_sched.sv
// Round-robin scheduler sharing one 8:1 bit mux among eight requesters,
// streaming the granted channel's bit over valid/ready with bounded bursts.
module mux81_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] din,
    input  logic       y_ready,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       y,
    output logic       y_valid,
    output logic       busy
);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BURST_LEN - 1);

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [CNTW-1:0] cnt;
    logic [SELW-1:0] ptr_nxt;
    logic [SELW-1:0] pick_idx;
    logic            pick_any;
    logic            accept;
    logic            release_gnt;

    assign busy        = (state == GRANT);
    assign y_valid     = busy && req[sel];
    assign accept      = y_valid && y_ready;
    assign release_gnt = busy && (!req[sel] || (accept && cnt == LAST_CNT));
    // Re-arbitration on release must already see the rotated pointer.
    assign ptr_nxt     = release_gnt ? sel + 3'd1 : ptr;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_nxt),
        .idx (pick_idx),
        .any (pick_any)
    );

    mux81 u_mux (
        .i0 (din[0]),
        .i1 (din[1]),
        .i2 (din[2]),
        .i3 (din[3]),
        .i4 (din[4]),
        .i5 (din[5]),
        .i6 (din[6]),
        .i7 (din[7]),
        .s2 (sel[2]),
        .s1 (sel[1]),
        .s0 (sel[0]),
        .y  (y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            sel   <= '0;
            gnt   <= '0;
        end else begin
            ptr <= ptr_nxt;
            if (state == IDLE || release_gnt) begin
                if (pick_any) begin
                    state <= GRANT;
                    sel   <= pick_idx;
                    gnt   <= 8'b1 << pick_idx;
                    cnt   <= '0;
                end else begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mux81_rr_sched.sv
// Bench for mux81_rr_sched: two instances (BURST_LEN 4 and 1) checked against
// a grant/burst reference model driven by directed and random request traffic.
module tb_mux81_rr_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic       y_ready;

    logic [2:0] sel0, sel1;
    logic [7:0] gnt0, gnt1;
    logic       y0, y1, yv0, yv1, busy0, busy1;

    int vectors = 0;
    int miscompares = 0;

    int m_g[2];
    int m_sel[2];
    int m_ptr[2];
    int m_cnt[2];
    int bl[2] = '{4, 1};

    always #5 clk = ~clk;

    mux81_rr_sched #(.BURST_LEN(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .y_ready(y_ready),
        .sel(sel0), .gnt(gnt0), .y(y0), .y_valid(yv0), .busy(busy0)
    );

    mux81_rr_sched #(.BURST_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .y_ready(y_ready),
        .sel(sel1), .gnt(gnt1), .y(y1), .y_valid(yv1), .busy(busy1)
    );

    function automatic int pick(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic cmp(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_g[u] = -1; m_sel[u] = 0; m_ptr[u] = 0; m_cnt[u] = 0;
        end
    endtask

    task automatic check_unit(int u);
        logic [7:0] eg, og, os;
        logic       ev, ov, oy, ob;
        eg = (m_g[u] >= 0) ? (8'd1 << m_g[u]) : 8'd0;
        ev = (m_g[u] >= 0) && req[m_g[u]];
        og = (u == 0) ? gnt0 : gnt1;
        os = (u == 0) ? {5'd0, sel0} : {5'd0, sel1};
        ov = (u == 0) ? yv0 : yv1;
        oy = (u == 0) ? y0 : y1;
        ob = (u == 0) ? busy0 : busy1;
        cmp($sformatf("gnt%0d", u), og, eg);
        cmp($sformatf("sel%0d", u), os, 8'(m_sel[u]));
        cmp($sformatf("y_valid%0d", u), {7'd0, ov}, {7'd0, ev});
        cmp($sformatf("busy%0d", u), {7'd0, ob}, {7'd0, m_g[u] >= 0});
        cmp($sformatf("y%0d", u), {7'd0, oy}, {7'd0, din[m_sel[u]]});
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step(int u);
        int  p;
        bit  valid, acc, rel;
        if (m_g[u] < 0) begin
            p = pick(req, m_ptr[u]);
            if (p >= 0) begin m_g[u] = p; m_sel[u] = p; m_cnt[u] = 0; end
        end else begin
            valid = req[m_g[u]];
            acc   = valid && y_ready;
            rel   = !valid || (acc && m_cnt[u] == bl[u] - 1);
            if (rel) begin
                m_ptr[u] = (m_g[u] + 1) % 8;
                p = pick(req, m_ptr[u]);
                if (p >= 0) begin m_g[u] = p; m_sel[u] = p; m_cnt[u] = 0; end
                else m_g[u] = -1;
            end else if (acc) begin
                m_cnt[u]++;
            end
        end
    endtask

    task automatic cycle(logic [7:0] r, logic [7:0] d, logic rdy);
        @(negedge clk);
        req = r; din = d; y_ready = rdy;
        #1;
        check_unit(0);
        check_unit(1);
        model_step(0);
        model_step(1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_unit(0);
        check_unit(1);
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        rst_n = 1'b0; req = 8'h00; din = 8'h00; y_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_unit(0);
        check_unit(1);
        rst_n = 1'b1;

        // Everyone requesting, consumer always ready.
        for (int i = 0; i < 40; i++) cycle(8'hFF, 8'($urandom), 1'b1);
        // Drain to idle, then a single new requester.
        for (int i = 0; i < 3; i++) cycle(8'h00, 8'($urandom), 1'b1);
        for (int i = 0; i < 6; i++) cycle(8'h40, 8'($urandom), 1'b1);

        // Mid-burst async reset with channel 5, then re-grant.
        for (int i = 0; i < 3; i++) cycle(8'h20, 8'($urandom), 1'b1);
        async_reset();
        for (int i = 0; i < 4; i++) cycle(8'h20, 8'($urandom), 1'b1);

        // Wrap-around pair and sole requester.
        for (int i = 0; i < 12; i++) cycle(8'h81, 8'($urandom), 1'b1);
        for (int i = 0; i < 10; i++) cycle(8'h01, 8'($urandom), 1'b1);

        // Stalls on a single channel.
        for (int i = 0; i < 12; i++) cycle(8'h08, 8'($urandom), 1'(($urandom_range(0, 2)) != 0));

        // Random traffic with sticky requests and random back-pressure.
        r = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
            cycle(r, 8'($urandom), 1'($urandom_range(0, 3) != 0));
            if (i == 200) async_reset();
        end
        for (int i = 0; i < 4; i++) cycle(8'h00, 8'($urandom), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
